// File: rtl/arm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// arm_ctrl_pkg
// Shared definitions for the multicycle ARM control unit:
//   - ctrl_state_t : controller FSM states (LINKWB only exists when
//                    BRANCH_LINK_EN is defined)
//   - ALU_*        : 3-bit ALU operation encodings driven on ALUControl
//   - OP_*         : instruction class codes from instruction bits [27:26]
//   - CMD_*        : data-processing command codes from Funct[4:1]
//   - is_cmp / is_known : command classification helpers
// ---------------------------------------------------------------------------
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
`ifdef BRANCH_LINK_EN
        S_BRANCH,
        S_LINKWB
`else
        S_BRANCH
`endif
    } ctrl_state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_EOR   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Compare-class commands update flags but never write a register.
    function automatic logic is_cmp(input logic [3:0] cmd);
        return (cmd == CMD_TST) || (cmd == CMD_TEQ) ||
               (cmd == CMD_CMP) || (cmd == CMD_CMN);
    endfunction

    // Commands the datapath implements; anything else runs as a harmless
    // ADD with every architectural write suppressed.
    function automatic logic is_known(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_EOR) || (cmd == CMD_SUB) ||
               (cmd == CMD_ADD) || (cmd == CMD_ORR) || (cmd == CMD_MOV) ||
               is_cmp(cmd);
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ---------------------------------------------------------------------------
// alu_dec
// Combinational ALU decoder for data-processing instructions.
// Ports:
//   funct   [4:0] in  : Funct[4:1] command code, Funct[0] S bit
//   exec          in  : controller is in EXECR/EXECI (and not in reset)
//   condex        in  : condition passed for the current instruction
//   alu_op  [2:0] out : ALU operation (ADD whenever exec is low)
//   flag_w  [1:0] out : flag write enables, bit1 = NZ, bit0 = CV
// ---------------------------------------------------------------------------
module alu_dec
    import arm_ctrl_pkg::*;
(
    input  logic [4:0] funct,
    input  logic       exec,
    input  logic       condex,
    output logic [2:0] alu_op,
    output logic [1:0] flag_w
);

    logic [3:0] cmd;
    logic [2:0] dec_op;
    logic       addsub;
    logic       flag_nz;

    assign cmd = funct[4:1];

    always_comb begin
        dec_op = ALU_ADD;
        addsub = 1'b0;
        case (cmd)
            CMD_ADD, CMD_CMN: begin dec_op = ALU_ADD; addsub = 1'b1; end
            CMD_SUB, CMD_CMP: begin dec_op = ALU_SUB; addsub = 1'b1; end
            CMD_AND, CMD_TST: dec_op = ALU_AND;
            CMD_ORR:          dec_op = ALU_ORR;
            CMD_EOR, CMD_TEQ: dec_op = ALU_EOR;
            CMD_MOV:          dec_op = ALU_PASSB;
            default:          dec_op = ALU_ADD;
        endcase
    end

    // Only arithmetic ops produce meaningful C/V, so the CV group rides on
    // the NZ enable qualified by the ADD/SUB class.
    assign flag_nz = exec & condex & is_known(cmd) & (funct[0] | is_cmp(cmd));
    assign flag_w  = {flag_nz, flag_nz & addsub};
    assign alu_op  = exec ? dec_op : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multicycle FSM control unit for the ARM datapath. Sequences
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory port with a
// MemReady handshake. Outputs are decoded from the state register and
// qualified combinationally by Funct, Rd, CondEx and MemReady.
//
// Optional feature macro: BRANCH_LINK_EN
//   defined   : BL (Op=10, Funct[4]=1) adds a LINKWB state and LinkSel port
//   undefined : Funct[4] ignored for branches, BL runs as plain B
//
// Parameters:
//   ALU_CTRL_W : ALUControl width (>= 3, upper bits driven zero)
//   FLAGW_W    : FlagW width (>= 2, bit1 = NZ, bit0 = CV)
// Ports:
//   clk, reset (async, active-low)
//   Op[1:0], Funct[5:0], Rd[3:0]  : instruction register fields
//   CondEx, MemReady              : condition result, memory handshake
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
//   ALUControl, FlagW, PCWrite, RegW, MemW : datapath controls
//   Illegal                       : one-cycle pulse on Op=11
//   LinkSel (BRANCH_LINK_EN only) : select PC-4 as R14 write data
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int FLAGW_W    = 2
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic                  CondEx,
    input  logic                  MemReady,
    output logic                  IRWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [FLAGW_W-1:0]    FlagW,
    output logic                  PCWrite,
    output logic                  RegW,
    output logic                  MemW,
`ifdef BRANCH_LINK_EN
    output logic                  LinkSel,
`endif
    output logic                  Illegal
);

    if (ALU_CTRL_W < 3) begin : g_bad_alu_ctrl_w
        $error("multicycle_ctrl: ALU_CTRL_W must be >= 3");
    end
    if (FLAGW_W < 2) begin : g_bad_flagw_w
        $error("multicycle_ctrl: FLAGW_W must be >= 2");
    end

    ctrl_state_t state_q, state_d;
    logic [3:0]  cmd;
    logic        cmp_cls;
    logic        known;
    logic        rd15;
    logic        exec;
    logic [2:0]  alu_op;
    logic [1:0]  flag_w;

    assign cmd     = Funct[4:1];
    assign cmp_cls = is_cmp(cmd);
    assign known   = is_known(cmd);
    assign rd15    = (Rd == 4'd15);

    // Qualifying with reset keeps ALUControl/FlagW at zero while held in reset.
    assign exec = reset & ((state_q == S_EXECR) || (state_q == S_EXECI));

    alu_dec u_alu_dec (
        .funct  (Funct[4:0]),
        .exec   (exec),
        .condex (CondEx),
        .alu_op (alu_op),
        .flag_w (flag_w)
    );

    assign ALUControl = ALU_CTRL_W'(alu_op);
    assign FlagW      = FLAGW_W'(flag_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'd0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        ImmSrc    = 2'd0;
        RegSrc    = 2'd0;
        PCWrite   = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Illegal   = 1'b0;
`ifdef BRANCH_LINK_EN
        LinkSel   = 1'b0;
`endif
        // Reset is asserted asynchronously; gating here forces every control
        // low immediately so an aborted instruction leaves no partial write.
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcA   = 2'd1;
                    ALUSrcB   = 2'd2;
                    ResultSrc = 2'd2;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcA   = 2'd1;
                    ALUSrcB   = 2'd2;
                    ResultSrc = 2'd2;
                    case (Op)
                        OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: begin
                            Illegal = 1'b1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_EXECR: begin
                    state_d = S_ALUWB;
                end
                S_EXECI: begin
                    ALUSrcB = 2'd1;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    // Unimplemented commands also must not redirect the PC.
                    RegW    = CondEx & known & ~cmp_cls & ~rd15;
                    PCWrite = CondEx & known & ~cmp_cls & rd15;
                    state_d = S_FETCH;
                end
                S_MEMADR: begin
                    ALUSrcB = 2'd1;
                    ImmSrc  = 2'd1;
                    state_d = Funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    AdrSrc = 1'b1;
                    if (MemReady) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = 2'd1;
                    RegW      = CondEx & ~rd15;
                    PCWrite   = CondEx & rd15;
                    state_d   = S_FETCH;
                end
                S_MEMWR: begin
                    AdrSrc = 1'b1;
                    RegSrc = 2'b10;
                    MemW   = CondEx;
                    // A failed condition never starts the bus write, so
                    // there is nothing to wait for.
                    if (MemReady || !CondEx) state_d = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'd1;
                    ImmSrc    = 2'd2;
                    RegSrc    = 2'b01;
                    ResultSrc = 2'd2;
                    PCWrite   = CondEx;
`ifdef BRANCH_LINK_EN
                    state_d   = Funct[4] ? S_LINKWB : S_FETCH;
`else
                    state_d   = S_FETCH;
`endif
                end
`ifdef BRANCH_LINK_EN
                S_LINKWB: begin
                    RegW    = CondEx;
                    LinkSel = 1'b1;
                    state_d = S_FETCH;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed test of multicycle_ctrl (default build, BRANCH_LINK_EN undefined).
// All outputs are packed into one vector and compared against hand-written
// expected vectors once per cycle, mid-cycle.
// Vector order: IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
//               ALUControl, FlagW, PCWrite, RegW, MemW, Illegal
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       MemReady;
    logic       IRWrite, AdrSrc, PCWrite, RegW, MemW, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW;
    logic [2:0] ALUControl;
    logic [20:0] obs;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .CondEx     (CondEx),
        .MemReady   (MemReady),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .PCWrite    (PCWrite),
        .RegW       (RegW),
        .MemW       (MemW),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
                  ALUControl, FlagW, PCWrite, RegW, MemW, Illegal};

    function automatic logic [20:0] mk(
        input logic irw, input logic adr, input logic [1:0] srca,
        input logic [1:0] srcb, input logic [1:0] res, input logic [1:0] imm,
        input logic [1:0] regsrc, input logic [2:0] aluc, input logic [1:0] flagw,
        input logic pcw, input logic regw, input logic memw, input logic ill);
        return {irw, adr, srca, srcb, res, imm, regsrc, aluc, flagw, pcw, regw, memw, ill};
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Check the current cycle mid-way, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [20:0] exp);
        #2;
        chk(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic ce);
        Op = op; Funct = fn; Rd = rd; CondEx = ce;
    endtask

    logic [20:0] zero_v, f_rdy, f_wait, dec_v, dec_ill;
    logic [20:0] memadr_v, memrd_v, memwr_v, memwr_nc;

    initial begin
        zero_v   = '0;
        f_rdy    = mk(1,0,2'd1,2'd2,2'd2,2'd0,2'b00,3'b000,2'b00,1,0,0,0);
        f_wait   = mk(0,0,2'd1,2'd2,2'd2,2'd0,2'b00,3'b000,2'b00,0,0,0,0);
        dec_v    = mk(0,0,2'd1,2'd2,2'd2,2'd0,2'b00,3'b000,2'b00,0,0,0,0);
        dec_ill  = mk(0,0,2'd1,2'd2,2'd2,2'd0,2'b00,3'b000,2'b00,0,0,0,1);
        memadr_v = mk(0,0,2'd0,2'd1,2'd0,2'd1,2'b00,3'b000,2'b00,0,0,0,0);
        memrd_v  = mk(0,1,2'd0,2'd0,2'd0,2'd0,2'b00,3'b000,2'b00,0,0,0,0);
        memwr_v  = mk(0,1,2'd0,2'd0,2'd0,2'd0,2'b10,3'b000,2'b00,0,0,1,0);
        memwr_nc = mk(0,1,2'd0,2'd0,2'd0,2'd0,2'b10,3'b000,2'b00,0,0,0,0);

        reset = 1'b0; MemReady = 1'b1;
        instr(2'b00, 6'b101000, 4'd1, 1'b1);

        // Held in reset: every output low even with MemReady high.
        #12;
        chk("reset_hold", zero_v);
        @(posedge clk); #1;
        chk("reset_hold2", zero_v);
        reset = 1'b1;

        // ADD R1,R2,#5
        cyc("add_fetch", f_rdy);
        cyc("add_decode", dec_v);
        cyc("add_execi", mk(0,0,2'd0,2'd1,2'd0,2'd0,2'b00,3'b000,2'b00,0,0,0,0));
        cyc("add_aluwb", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b000,2'b00,0,1,0,0));

        // CMP (S=1), CondEx=1
        instr(2'b00, 6'b010101, 4'd0, 1'b1);
        cyc("cmp_fetch", f_rdy);
        cyc("cmp_decode", dec_v);
        cyc("cmp_execr", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b001,2'b11,0,0,0,0));
        cyc("cmp_aluwb", zero_v);

        // CMP, CondEx=0
        instr(2'b00, 6'b010101, 4'd0, 1'b0);
        cyc("cmpnc_fetch", f_rdy);
        cyc("cmpnc_decode", dec_v);
        cyc("cmpnc_execr", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b001,2'b00,0,0,0,0));
        cyc("cmpnc_aluwb", zero_v);

        // EORS R2: NZ only, CV group stays off for logical ops
        instr(2'b00, 6'b000011, 4'd2, 1'b1);
        cyc("eor_fetch", f_rdy);
        cyc("eor_decode", dec_v);
        cyc("eor_execr", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b100,2'b10,0,0,0,0));
        cyc("eor_aluwb", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b000,2'b00,0,1,0,0));

        // MOV PC,#imm: PASS-B, PC written instead of register file
        instr(2'b00, 6'b111010, 4'd15, 1'b1);
        cyc("movpc_fetch", f_rdy);
        cyc("movpc_decode", dec_v);
        cyc("movpc_execi", mk(0,0,2'd0,2'd1,2'd0,2'd0,2'b00,3'b101,2'b00,0,0,0,0));
        cyc("movpc_aluwb", mk(0,0,2'd0,2'd0,2'd0,2'd0,2'b00,3'b000,2'b00,1,0,0,0));

        // Unimplemented command 0111 with S=1: ADD, no flag or register write
        instr(2'b00, 6'b001111, 4'd3, 1'b1);
        cyc("unk_fetch", f_rdy);
        cyc("unk_decode", dec_v);
        cyc("unk_execr", zero_v);
        cyc("unk_aluwb", zero_v);

        // LDR R4: one FETCH wait, MemReady ignored in DECODE/MEMADR,
        // three MEMRD wait cycles
        instr(2'b01, 6'b011001, 4'd4, 1'b1);
        MemReady = 1'b0;
        cyc("ldr_fetch_wait", f_wait);
        MemReady = 1'b1;
        cyc("ldr_fetch", f_rdy);
        MemReady = 1'b0;
        cyc("ldr_decode", dec_v);
        cyc("ldr_memadr", memadr_v);
        cyc("ldr_memrd1", memrd_v);
        cyc("ldr_memrd2", memrd_v);
        cyc("ldr_memrd3", memrd_v);
        MemReady = 1'b1;
        cyc("ldr_memrd4", memrd_v);
        cyc("ldr_memwb", mk(0,0,2'd0,2'd0,2'd1,2'd0,2'b00,3'b000,2'b00,0,1,0,0));

        // LDR PC
        instr(2'b01, 6'b011001, 4'd15, 1'b1);
        cyc("ldrpc_fetch", f_rdy);
        cyc("ldrpc_decode", dec_v);
        cyc("ldrpc_memadr", memadr_v);
        cyc("ldrpc_memrd", memrd_v);
        cyc("ldrpc_memwb", mk(0,0,2'd0,2'd0,2'd1,2'd0,2'b00,3'b000,2'b00,1,0,0,0));

        // STR R5 with two wait cycles: MemW high three cycles
        instr(2'b01, 6'b011000, 4'd5, 1'b1);
        cyc("str_fetch", f_rdy);
        cyc("str_decode", dec_v);
        cyc("str_memadr", memadr_v);
        MemReady = 1'b0;
        cyc("str_memwr1", memwr_v);
        cyc("str_memwr2", memwr_v);
        MemReady = 1'b1;
        cyc("str_memwr3", memwr_v);

        // STR with CondEx=0: no strobe, back to FETCH without waiting
        instr(2'b01, 6'b011000, 4'd5, 1'b0);
        cyc("strnc_fetch", f_rdy);
        cyc("strnc_decode", dec_v);
        cyc("strnc_memadr", memadr_v);
        MemReady = 1'b0;
        cyc("strnc_memwr", memwr_nc);
        cyc("strnc_back_fetch", f_wait);
        MemReady = 1'b1;

        // B (Funct[4]=1, BL form, runs as B in this build)
        instr(2'b10, 6'b010000, 4'd0, 1'b1);
        cyc("b_fetch", f_rdy);
        cyc("b_decode", dec_v);
        cyc("b_branch", mk(0,0,2'd0,2'd1,2'd2,2'd2,2'b01,3'b000,2'b00,1,0,0,0));

        // Op=11: Illegal pulse for exactly one cycle
        instr(2'b11, 6'b000000, 4'd0, 1'b1);
        cyc("ill_fetch", f_rdy);
        cyc("ill_decode", dec_ill);
        cyc("ill_back_fetch", f_rdy);

        // STR interrupted by reset while in MEMWR
        instr(2'b01, 6'b011000, 4'd6, 1'b1);
        cyc("rst_decode", dec_v);
        cyc("rst_memadr", memadr_v);
        MemReady = 1'b0;
        #2;
        chk("rst_memwr", memwr_v);
        reset = 1'b0;
        #1;
        chk("rst_abort_now", zero_v);
        @(posedge clk); #1;
        chk("rst_abort_held", zero_v);
        reset = 1'b1;
        cyc("rst_first_fetch", f_wait);
        MemReady = 1'b1;
        cyc("rst_fetch_rdy", f_rdy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Next-generation control unit for the ARM core; replaces the single-cycle decoder with a multicycle FSM controller.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory port.
- Adds a memory-ready handshake, parametrised ALU control width and EOR support.
- Sits between the instruction register fields and the multicycle datapath; conditional logic outside this block supplies CondEx.

Parameters:
- ALU_CTRL_W, 3, ALUControl width; must be >=3. Elaboration error if smaller.
- FLAGW_W, 2, FlagW width; bit1 = NZ group, bit0 = CV group.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- Op  input  2  instruction [27:26]
- Funct  input  6  instruction [25:20]
- Rd  input  4  instruction [15:12]
- CondEx  input  1  condition passed for current instruction
- MemReady  input  1  memory completes access this cycle
- IRWrite  output  1  load instruction register
- AdrSrc  output  1  0=PC, 1=ALU result register
- ALUSrcA  output  2  0=Rn, 1=PC, 2=zero
- ALUSrcB  output  2  0=Rm/shifted, 1=ExtImm, 2=const 4
- ResultSrc  output  2  0=ALUOut, 1=Data, 2=ALU direct
- ImmSrc  output  2  imm format: 0=DP, 1=mem, 2=branch
- RegSrc  output  2  register-address selects (STR Rd read, branch PC)
- ALUControl  output  ALU_CTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 PASS-B; upper bits zero
- FlagW  output  FLAGW_W  flag-write enables
- PCWrite  output  1  PC load enable
- RegW  output  1  register-file write enable
- MemW  output  1  memory write strobe
- Illegal  output  1  one-cycle pulse on unimplemented Op

Behaviour:
- Reset state is FETCH. All outputs are 0 during reset and while reset is asserted mid-operation; that aborts the instruction with no partial writes.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ResultSrc=2.
  - Holds until MemReady=1. In that cycle asserts IRWrite=1 and PCWrite=1, then goes to DECODE.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=2, ResultSrc=2 (PC+8 read).
  - Op=00, Funct[5]=0 -> EXECR; Op=00, Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH.
  - Op=11 -> Illegal=1, then FETCH.
- EXECR/EXECI:
  - ALUSrcA=0. ALUSrcB=0 in EXECR, 1 in EXECI. ImmSrc=0.
  - ALU decode on Funct[4:1]:
    - 0100 ADD, 1011 CMN -> ADD.
    - 0010 SUB, 1010 CMP -> SUB.
    - 0000 AND, 1000 TST -> AND.
    - 1100 ORR -> ORR.
    - 0001 EOR, 1001 TEQ -> EOR.
    - 1101 MOV -> PASS-B.
    - Any other code -> ADD, with RegW and FlagW suppressed.
  - FlagW[1] = CondEx & (S | compare-class).
  - FlagW[0] = FlagW[1] & (ADD|SUB class).
  - Compare-class ops (CMP/CMN/TST/TEQ) set flags regardless of S.
  - Then go to ALUWB.
- ALUWB:
  - ResultSrc=0.
  - RegW = CondEx & !compare-class & !Rd15.
  - PCWrite = CondEx & Rd==15 & !compare-class.
  - Then FETCH.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=1, ImmSrc=1, ALUControl=ADD.
  - Funct[0]=1 -> MEMRD; otherwise -> MEMWR.
- MEMRD:
  - AdrSrc=1. Holds until MemReady, then MEMWB.
- MEMWB:
  - ResultSrc=1.
  - RegW = CondEx & Rd!=15; PCWrite = CondEx & Rd==15.
  - Then FETCH.
- MEMWR:
  - AdrSrc=1, RegSrc[1]=1, MemW=CondEx.
  - MemW stays asserted until the MemReady cycle, then FETCH.
  - If CondEx=0, the state skips straight to FETCH without waiting.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=1, ImmSrc=2, RegSrc[0]=1, ResultSrc=2.
  - PCWrite=CondEx. Then FETCH.
- MemReady is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Latency with MemReady tied high:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- The state register is the only sequential element. Outputs are Moore/state-decoded, plus combinational qualification by Funct, Rd, CondEx and MemReady.

Optional Feature:
- Macro BRANCH_LINK_EN.
- With the macro defined: Op=10 with Funct[4]=1 (BL) goes BRANCH -> LINKWB. LINKWB drives RegW=CondEx and asserts a LinkSel output, which makes the datapath write PC-4 into R14. LINKWB then goes to FETCH; BL takes 4 cycles.
- Without the macro: Funct[4] is ignored, there is no LINKWB state and no LinkSel port; BL executes as plain B.

Decomposition:
- Package arm_ctrl_pkg holds:
  - state enum ctrl_state_t.
  - ALU opcode localparams (ALU_ADD..ALU_PASSB).
  - Op-class constants (OP_DP, OP_MEM, OP_BR).
  - Funct[4:1] command codes.
- One sub-module, alu_dec: combinational. Funct, state-class and CondEx in; ALUControl and FlagW out.

Test Plan:
- ADD R1,R2,#5 (Op=00, Funct=101000), CondEx=1, MemReady=1 -> FETCH/DECODE/EXECI/ALUWB. ALUControl=000 in EXECI, RegW=1 in ALUWB, FlagW=00 throughout.
- CMP (Funct=010101) -> FlagW=11 in EXECR, RegW=0 in ALUWB. CondEx=0 variant -> FlagW=00.
- LDR with MemReady low for 3 cycles in MEMRD -> stays in MEMRD 4 cycles, then MEMWB RegW=1. With Rd=15, MEMWB gives PCWrite=1 and RegW=0.
- STR, MemReady low for 2 cycles -> MemW=1 for 3 consecutive cycles. CondEx=0 variant -> MemW never asserted, returns to FETCH next cycle.
- B with CondEx=1 -> PCWrite=1 in BRANCH, ImmSrc=10. Op=11 -> Illegal=1 for one cycle, then FETCH.
- Reset_low asserted in MEMWR -> all outputs 0 immediately. After release, first cycle is FETCH.
